// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC sample controller: FSM encoding, frame geometry
// and the leading-zero check used when ADC_FRAME_CHECK_EN is defined.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_QUIET = 3'd4
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_ZEROS = 4;

  // True when any of the frame's leading bits, which the ADC always sends as zero, is set.
  function automatic logic lead_zeros_bad(input logic [FRAME_BITS-1:0] frame);
    return (frame[FRAME_BITS-1 -: LEAD_ZEROS] != {LEAD_ZEROS{1'b0}});
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: SCLK level (idles high) plus one-cycle rise/fall
// enables, all on clk. A low run input parks SCLK high and clears the divider.
module adc_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             half_done;

  // Enables mark the clk edge on which SCLK toggles.
  assign half_done = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sclk_rise = half_done && !sclk;
  assign sclk_fall = half_done && sclk;

  // Half-period divider and SCLK level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sclk    <= 1'b1;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b1;
    end else if (half_done) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_sample_controller.sv
// Master sequencer for a 12-bit serial ADC (16-bit frames). Optional macro
// ADC_FRAME_CHECK_EN adds the frame_err port flagging non-zero leading bits.
module adc_sample_controller
  import adc_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 1000,
  parameter int QUIET_CYC  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        SDATA,
  output logic        CS,
  output logic        SCLK,
  output logic [11:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        overrun
`ifdef ADC_FRAME_CHECK_EN
  ,
  output logic        frame_err
`endif
);

  localparam int TMR_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int Q_W   = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
`ifdef ADC_FRAME_CHECK_EN
  localparam int SH_W  = FRAME_BITS;
`else
  localparam int SH_W  = DATA_BITS;
`endif

  state_t            state;
  state_t            state_next;
  logic [TMR_W-1:0]  timer;
  logic              timer_tick;
  logic              trigger;
  logic [4:0]        bit_cnt;
  logic [Q_W-1:0]    quiet_cnt;
  logic [SH_W-1:0]   shreg;
  logic              sclk_run;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_next;
  logic              busy_next;
  logic              valid_next;
  logic              overrun_next;

  assign timer_tick = enable && (timer == TMR_W'(SAMPLE_DIV - 1));
  assign trigger    = start | timer_tick;
  assign sclk_run   = (state == ST_SHIFT);

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .run       (sclk_run),
    .sclk      (SCLK),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // Periodic trigger timer, held at zero while sampling is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!enable || timer_tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus next values of the registered outputs.
  // bit_cnt counts falling edges, so it reads 16 when the last rising edge arrives.
  always_comb begin
    state_next   = state;
    overrun_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_next   = ST_SHIFT;
        overrun_next = trigger;
      end
      ST_SHIFT: begin
        overrun_next = trigger;
        if (sclk_rise && (bit_cnt == 5'(FRAME_BITS))) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_next   = ST_QUIET;
        overrun_next = trigger;
      end
      ST_QUIET: begin
        overrun_next = trigger;
        if (quiet_cnt == Q_W'(QUIET_CYC - 1)) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_QUIET;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    cs_next    = (state_next != ST_SHIFT);
    busy_next  = (state_next != ST_IDLE);
    valid_next = (state == ST_DONE);
  end

  // Frame datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CS         <= 1'b1;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      data_out   <= 12'h000;
      bit_cnt    <= 5'd0;
      quiet_cnt  <= '0;
      shreg      <= '0;
    end else begin
      CS         <= cs_next;
      busy       <= busy_next;
      data_valid <= valid_next;
      overrun    <= overrun_next;
      if (state == ST_LOAD) begin
        bit_cnt <= 5'd0;
        shreg   <= '0;
      end else if (state == ST_SHIFT) begin
        if (sclk_fall) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
        if (sclk_rise) begin
          shreg <= {shreg[SH_W-2:0], SDATA};
        end
      end
      if (state == ST_DONE) begin
        data_out  <= shreg[DATA_BITS-1:0];
        quiet_cnt <= '0;
      end else if (state == ST_QUIET) begin
        quiet_cnt <= quiet_cnt + 1'b1;
      end
    end
  end

`ifdef ADC_FRAME_CHECK_EN
  // Leading-bit check, pulsed alongside data_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= (state == ST_DONE) && lead_zeros_bad(shreg);
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_controller.sv
// Directed bench for adc_sample_controller with an ADC pin model and a
// scoreboard of expected frames checked whenever data_valid strobes.
`timescale 1ns/1ps
module tb_adc_sample_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        SDATA = 1'b0;
  logic        CS;
  logic        SCLK;
  logic [11:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        overrun;
`ifdef ADC_FRAME_CHECK_EN
  logic        frame_err;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int ovr_cnt = 0;
  int rise_cnt = 0;
  int bit_idx = 15;
  int busy_gap = 0;
  bit chk_busy = 1'b0;
  int trig_cyc = 0;
  int en_cyc = 0;
  int n0 = 0;
  int o0 = 0;
  int v1 = 0;
  logic [15:0] cur_frame = 16'h0000;
  logic [15:0] mon_f;
  logic [15:0] frame_q[$];
  logic [15:0] exp_q[$];

  adc_sample_controller #(
    .CLK_DIV    (2),
    .SAMPLE_DIV (200),
    .QUIET_CYC  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .SDATA      (SDATA),
    .CS         (CS),
    .SCLK       (SCLK),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun)
`ifdef ADC_FRAME_CHECK_EN
    ,
    .frame_err  (frame_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model: new frame on CS fall, next bit driven on each SCLK fall.
  always @(negedge CS) begin
    cur_frame = (frame_q.size() > 0) ? frame_q.pop_front() : 16'h0000;
    bit_idx = 15;
    rise_cnt = 0;
  end

  always @(negedge SCLK) begin
    if (!CS && bit_idx >= 0) begin
      SDATA = cur_frame[bit_idx];
      bit_idx--;
    end
  end

  always @(posedge SCLK) begin
    if (!CS) rise_cnt++;
  end

  // Output monitor and scoreboard compare.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        check("sb_has_entry", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_f = exp_q.pop_front();
          check("data_out", data_out, mon_f[11:0]);
          check("cs_high_at_valid", CS, 1);
`ifdef ADC_FRAME_CHECK_EN
          check("frame_err", frame_err, (mon_f[15:12] != 4'h0));
`endif
        end
      end
      if (overrun) ovr_cnt++;
      if (chk_busy && !busy) busy_gap++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
    trig_cyc = cyc;
  endtask

  task automatic push_frame(input logic [15:0] f);
    frame_q.push_back(f);
    exp_q.push_back(f);
  endtask

  task automatic wait_valid(input int base, input int budget, input string tag);
    int k;
    k = 0;
    while (valid_cnt <= base && k < budget) begin
      step(1);
      k++;
    end
    if (valid_cnt <= base) check(tag, 0, 1);
  endtask

  initial begin
    // 1: reset state, single-shot frame and latency
    step(5);
    check("rst_cs", CS, 1);
    check("rst_sclk", SCLK, 1);
    check("rst_data_out", data_out, 12'h000);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
`ifdef ADC_FRAME_CHECK_EN
    check("rst_frame_err", frame_err, 0);
`endif
    reset = 1'b0;
    step(2);
    push_frame(16'h0ABC);
    n0 = valid_cnt;
    pulse_start();
    check("t1_busy_after_trig", busy, 1);
    step(3);
    check("t1_cs_low_shift", CS, 0);
    wait_valid(n0, 200, "t1_valid_timeout");
    check("t1_latency", last_valid_cyc - trig_cyc, 66);
    step(10);
    check("t1_busy_idle", busy, 0);

    // 2: periodic sampling every 200 cycles
    push_frame(16'h0001);
    push_frame(16'h0FFF);
    o0 = ovr_cnt;
    n0 = valid_cnt;
    enable = 1'b1;
    step(1);
    en_cyc = cyc;
    wait_valid(n0, 400, "t2_first_timeout");
    check("t2_first_at", last_valid_cyc - en_cyc, 265);
    v1 = last_valid_cyc;
    wait_valid(n0 + 1, 300, "t2_second_timeout");
    enable = 1'b0;
    check("t2_period", last_valid_cyc - v1, 200);
    check("t2_no_overrun", ovr_cnt - o0, 0);

    // 3: start while busy -> overrun, single frame, busy unbroken
    step(20);
    push_frame(16'h0A5A);
    o0 = ovr_cnt;
    n0 = valid_cnt;
    busy_gap = 0;
    pulse_start();
    chk_busy = 1'b1;
    v1 = trig_cyc;
    step(9);
    pulse_start();
    wait_valid(n0, 200, "t3_valid_timeout");
    chk_busy = 1'b0;
    check("t3_latency", last_valid_cyc - v1, 66);
    check("t3_overrun_pulses", ovr_cnt - o0, 1);
    check("t3_busy_gap", busy_gap, 0);
    step(100);
    check("t3_single_valid", valid_cnt - n0, 1);

    // 4: reset in the middle of SHIFT
    frame_q.push_back(16'h0FFF);
    n0 = valid_cnt;
    rise_cnt = 0;
    pulse_start();
    begin
      int k;
      k = 0;
      while (rise_cnt < 7 && k < 200) begin
        @(posedge SCLK or posedge clk);
        #1;
        k++;
      end
    end
    check("t4_rise7_reached", rise_cnt, 7);
    reset = 1'b1;
    #1;
    check("t4_rst_cs", CS, 1);
    check("t4_rst_sclk", SCLK, 1);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_valid", data_valid, 0);
    step(3);
    reset = 1'b0;
    step(100);
    check("t4_no_valid_aborted", valid_cnt - n0, 0);
    push_frame(16'h0555);
    pulse_start();
    wait_valid(n0, 200, "t4_clean_timeout");
    check("t4_clean_latency", last_valid_cyc - trig_cyc, 66);

    // 5: start coincident with timer tick -> one frame, no overrun
    step(10);
    push_frame(16'h0321);
    o0 = ovr_cnt;
    n0 = valid_cnt;
    enable = 1'b1;
    step(1);
    en_cyc = cyc;
    step(198);
    start = 1'b1;
    step(1);
    start = 1'b0;
    enable = 1'b0;
    trig_cyc = cyc;
    wait_valid(n0, 200, "t5_valid_timeout");
    check("t5_latency", last_valid_cyc - trig_cyc, 66);
    step(150);
    check("t5_single_valid", valid_cnt - n0, 1);
    check("t5_no_overrun", ovr_cnt - o0, 0);

    // 6: leading frame bits (ignored, or flagged with ADC_FRAME_CHECK_EN)
    step(10);
    push_frame(16'h8123);
    n0 = valid_cnt;
    pulse_start();
    wait_valid(n0, 200, "t6a_timeout");
    step(10);
    push_frame(16'h0123);
    pulse_start();
    wait_valid(n0 + 1, 200, "t6b_timeout");
    step(10);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
